// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 4-word lines refilled one word
// at a time over a request/status memory handshake.
`timescale 1ns/1ps
module instruction_cache #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned DATA_LEN   = 32,
   parameter int unsigned LINE_NUM   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_enable,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  flush,
   output logic                  inst_valid,
   output logic [DATA_LEN-1:0]   inst,
   output logic [1:0]            i_cache_mem_vis_signal,
   output logic [ADDR_WIDTH-1:0] i_cache_mem_vis_addr,
   input  logic [DATA_LEN-1:0]   mem_data,
   input  logic [1:0]            mem_status
);
   localparam int unsigned IDX_W = $clog2(LINE_NUM);
   localparam int unsigned TAG_W = ADDR_WIDTH - 4 - IDX_W;
   localparam int unsigned BYTES = DATA_LEN / 8;

   localparam logic [1:0] MEM_NOP           = 2'b00;
   localparam logic [1:0] MEM_READ          = 2'b01;
   localparam logic [1:0] MEM_INST_FINISHED = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e              state_q;
   logic [1:0]          cnt_q;
   logic [LINE_NUM-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [LINE_NUM];
   logic [DATA_LEN-1:0] data_q [LINE_NUM][4];

   logic [1:0]          offset_c;
   logic [IDX_W-1:0]    index_c;
   logic [TAG_W-1:0]    tag_c;
   logic                hit_c;
   logic                capture_c;
   logic [DATA_LEN-1:0] line_word_c;
   logic                unused_c;

   // Memory delivers the lowest-addressed byte in the top lane; the core wants little-endian.
   function automatic logic [DATA_LEN-1:0] swap_bytes(input logic [DATA_LEN-1:0] w);
      swap_bytes = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         swap_bytes[8*i +: 8] = w[DATA_LEN-8-8*i +: 8];
      end
   endfunction

   assign offset_c    = pc[3:2];
   assign index_c     = pc[4 +: IDX_W];
   assign tag_c       = pc[ADDR_WIDTH-1 -: TAG_W];
   assign hit_c       = valid_q[index_c] && (tag_q[index_c] == tag_c);
   assign capture_c   = (state_q == REQ) && (mem_status == MEM_INST_FINISHED);
   assign line_word_c = swap_bytes(mem_data);
   assign unused_c    = ^pc[1:0];

   // Line storage is never reset; only the valid bits gate visibility.
   always_ff @(posedge clk) begin
      if (capture_c) begin
         data_q[index_c][cnt_q] <= line_word_c;
         if (cnt_q == 2'd3) begin
            tag_q[index_c] <= tag_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q                <= IDLE;
         cnt_q                  <= 2'd0;
         valid_q                <= '0;
         inst_valid             <= 1'b0;
         inst                   <= '0;
         i_cache_mem_vis_signal <= MEM_NOP;
         i_cache_mem_vis_addr   <= '0;
      end else begin
         inst_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush) begin
                  valid_q <= '0;
               end else if (fetch_enable) begin
                  if (hit_c) begin
                     inst       <= data_q[index_c][offset_c];
                     inst_valid <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     cnt_q                  <= 2'd0;
                     i_cache_mem_vis_signal <= MEM_READ;
                     i_cache_mem_vis_addr   <= {pc[ADDR_WIDTH-1:4], 2'b00, 2'b00};
                     state_q                <= REQ;
                  end
               end
            end
            REQ: begin
               if (capture_c) begin
                  i_cache_mem_vis_signal <= MEM_NOP;
                  if (cnt_q == 2'd3) begin
                     // Last word completes the line; forward it directly if it is the one requested.
                     valid_q[index_c] <= 1'b1;
                     inst       <= (offset_c == 2'd3) ? line_word_c : data_q[index_c][offset_c];
                     inst_valid <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     state_q <= GAP;
                  end
               end
            end
            GAP: begin
               cnt_q                  <= cnt_q + 2'd1;
               i_cache_mem_vis_signal <= MEM_READ;
               i_cache_mem_vis_addr   <= {pc[ADDR_WIDTH-1:4], cnt_q + 2'd1, 2'b00};
               state_q                <= REQ;
            end
            RESP: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: table of fetches against a byte-addressed memory model,
// plus reset-mid-refill and flush sequences.
`timescale 1ns/1ps
module tb_instruction_cache;
   localparam int unsigned AW = 17;
   localparam int unsigned DW = 32;
   localparam logic [1:0] MEM_NOP     = 2'b00;
   localparam logic [1:0] MEM_READ    = 2'b01;
   localparam logic [1:0] ST_RESTING  = 2'b00;
   localparam logic [1:0] ST_INST     = 2'b01;
   localparam logic [1:0] ST_DATA     = 2'b10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_enable = 1'b0;
   logic          flush = 1'b0;
   logic [AW-1:0] pc = '0;
   logic          inst_valid;
   logic [DW-1:0] inst;
   logic [1:0]    sig;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mem_data = '0;
   logic [1:0]    mem_status = ST_RESTING;

   int checks = 0;
   int failures = 0;
   int stall_budget = 0;
   int stall_done = 0;
   logic [DW-1:0] exp_q [$];
   logic [AW-1:0] rd_q  [$];

   typedef struct {
      logic [AW-1:0] pc;
      bit            miss;
      int            stall;
      int            fmode;
      int            lat;
   } vec_t;
   vec_t vecs [13];

   always #5 clk = ~clk;

   instruction_cache #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .LINE_NUM(16)) u_dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .fetch_enable           (fetch_enable),
      .pc                     (pc),
      .flush                  (flush),
      .inst_valid             (inst_valid),
      .inst                   (inst),
      .i_cache_mem_vis_signal (sig),
      .i_cache_mem_vis_addr   (maddr),
      .mem_data               (mem_data),
      .mem_status             (mem_status)
   );

   function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
      case (a)
         17'h0:   byte_at = 8'h13;
         17'h1:   byte_at = 8'h05;
         17'h2:   byte_at = 8'h00;
         17'h3:   byte_at = 8'h00;
         default: byte_at = 8'((32'(a) * 32'd37) + (32'(a) >> 3) + 32'd1);
      endcase
   endfunction

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      mem_word = {byte_at(a), byte_at(AW'(a + 17'd1)), byte_at(AW'(a + 17'd2)), byte_at(AW'(a + 17'd3))};
   endfunction

   function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
      logic [AW-1:0] w;
      w = {a[AW-1:2], 2'b00};
      exp_word = {byte_at(AW'(w + 17'd3)), byte_at(AW'(w + 17'd2)), byte_at(AW'(w + 17'd1)), byte_at(w)};
   endfunction

   // Memory: one-cycle registered response, optional DATA_FINISHED stalls first.
   always @(posedge clk) begin
      if (sig == MEM_READ && stall_done < stall_budget) begin
         mem_status <= ST_DATA;
         stall_done <= stall_done + 1;
      end else if (sig == MEM_READ && mem_status != ST_INST) begin
         mem_status <= ST_INST;
         mem_data   <= mem_word(maddr);
         rd_q.push_back(maddr);
      end else begin
         mem_status <= ST_RESTING;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_valid"}, 64'(inst_valid), 64'd0);
      check({name, "_inst"},  64'(inst), 64'd0);
      check({name, "_sig"},   64'(sig), 64'(MEM_NOP));
      check({name, "_addr"},  64'(maddr), 64'd0);
   endtask

   // fmode: 0 none, 1 flush together with the fetch, 2 flush held during the refill.
   task automatic do_fetch(input logic [AW-1:0] a, input bit exp_miss, input int exp_lat,
                           input int stall_n, input int fmode, input string name);
      int            base;
      int            lat;
      int            stall_seen;
      int            nrd;
      bit            got;
      logic [DW-1:0] exp_inst;
      logic [AW-1:0] line_addr;
      line_addr  = {a[AW-1:4], 4'b0000};
      base       = rd_q.size();
      stall_seen = 0;
      stall_budget = stall_budget + stall_n;
      @(negedge clk);
      pc = a;
      fetch_enable = 1'b1;
      flush = (fmode == 1);
      exp_q.push_back(exp_word(a));
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (fmode == 1) flush = 1'b0;
         if (fmode == 2) flush = 1'b1;
         if (mem_status == ST_DATA) begin
            stall_seen++;
            check({name, "_hold_sig"},  64'(sig), 64'(MEM_READ));
            check({name, "_hold_addr"}, 64'(maddr), 64'(line_addr));
         end
         if (inst_valid) got = 1'b1;
      end
      fetch_enable = 1'b0;
      flush = 1'b0;
      check({name, "_got_valid"}, 64'(got), 64'd1);
      exp_inst = exp_q.pop_front();
      if (got) begin
         check({name, "_inst"}, 64'(inst), 64'(exp_inst));
         check({name, "_sig_nop"}, 64'(sig), 64'(MEM_NOP));
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_stalls"}, 64'(stall_seen), 64'(stall_n));
      nrd = rd_q.size() - base;
      check({name, "_nreads"}, 64'(nrd), exp_miss ? 64'd4 : 64'd0);
      if (exp_miss && nrd == 4) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rd%0d", name, k), 64'(rd_q[base+k]), 64'(line_addr + AW'(4*k)));
         end
      end
      @(posedge clk);
      #1;
      check({name, "_pulse"}, 64'(inst_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{17'h000, 1'b1, 0, 0, 12};
      vecs[1]  = '{17'h004, 1'b0, 0, 0, 1};
      vecs[2]  = '{17'h00C, 1'b0, 0, 0, 1};
      vecs[3]  = '{17'h100, 1'b1, 0, 0, 12};
      vecs[4]  = '{17'h000, 1'b1, 0, 0, 12};
      vecs[5]  = '{17'h02C, 1'b1, 0, 0, 12};
      vecs[6]  = '{17'h028, 1'b0, 0, 0, 1};
      vecs[7]  = '{17'h1FC, 1'b1, 0, 0, 12};
      vecs[8]  = '{17'h1F0, 1'b0, 0, 0, 1};
      vecs[9]  = '{17'h300, 1'b1, 3, 0, 15};
      vecs[10] = '{17'h308, 1'b0, 0, 0, 1};
      vecs[11] = '{17'h050, 1'b1, 0, 2, 12};
      vecs[12] = '{17'h054, 1'b0, 0, 0, 1};

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         do_fetch(vecs[i].pc, vecs[i].miss, vecs[i].lat, vecs[i].stall, vecs[i].fmode,
                  $sformatf("v%0d", i));
      end

      // Reset after two words of a refill have been captured.
      @(negedge clk);
      pc = 17'h000;
      fetch_enable = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("midfill_sig",  64'(sig), 64'(MEM_READ));
      check("midfill_addr", 64'(maddr), 64'h8);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      fetch_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_fetch(17'h000, 1'b1, 12, 0, 0, "after_reset");
      do_fetch(17'h014, 1'b1, 12, 0, 0, "fill_idx1");
      do_fetch(17'h004, 1'b0, 1,  0, 0, "pre_flush_hit");
      do_fetch(17'h000, 1'b1, 13, 0, 1, "flush_fetch");
      do_fetch(17'h018, 1'b1, 12, 0, 0, "post_flush_idx1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
